// File: rtl/debug_pkg.sv
// debug_pkg: shared types and constants for the board-level execution
// controller (debug_step_ctrl) and its key debouncer.
//   mode_e     : operating mode selected by the switches
//   state_e    : controller state
//   SEG_LUT    : active-low seven-segment patterns (gfedcba) for 0..F
//   SEG_BLANK  : all segments off
package debug_pkg;

   typedef enum logic [1:0] {
      MODE_HALT  = 2'b00,
      MODE_RUN   = 2'b01,
      MODE_STEP  = 2'b10,
      MODE_BURST = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_BURST
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      return SEG_LUT[nib];
   endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchroniser + debouncer for an active-low push-button.
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_key_n  : raw, asynchronous, bouncing key (0 = pressed)
//   o_press  : one-cycle pulse on each debounced press (falling edge)
// The debounced level flips only after DB_CYC consecutive synchronised
// samples that differ from it; any agreeing sample restarts the count.
module key_debounce #(
   parameter int unsigned DB_CYC = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_press
);

   localparam int unsigned CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b1;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
            r_press <= ~r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: single-clock execution controller. The core always runs on
// clk and is advanced through cpu_ce_o in halt, free-run, single-step or
// N-cycle burst mode; a selectable 32-bit debug word is shown on HEX digits.
// Optional feature macro: DEBUG_STEP_HEX_EN (display register + segment
// decode present; when undefined hex_o is blank and ch_sel_i/dbg_i unused).
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   mode_i       : 00 HALT, 01 RUN, 10 STEP, 11 BURST (asynchronous switches)
//   key_step_n   : raw active-low step key
//   burst_len_i  : enable cycles per burst
//   ch_sel_i     : debug channel shown on the display
//   dbg_i        : NUM_CH debug words, channel k at [32k+31:32k]
//   cpu_ce_o     : clock enable to the core
//   busy_o       : step/burst in progress
//   cyc_cnt_o    : enabled cycles since reset (wraps)
//   hex_o        : active-low segments, digit d at [7d+6:7d], order gfedcba
module debug_step_ctrl
   import debug_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 10,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned NUM_HEX     = 6,
   parameter int unsigned BURST_W     = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [1:0]                 mode_i,
   input  logic                       key_step_n,
   input  logic [BURST_W-1:0]         burst_len_i,
   input  logic [$clog2(NUM_CH)-1:0]  ch_sel_i,
   input  logic [NUM_CH*32-1:0]       dbg_i,
   output logic                       cpu_ce_o,
   output logic                       busy_o,
   output logic [31:0]                cyc_cnt_o,
   output logic [NUM_HEX*7-1:0]       hex_o
);

   localparam int unsigned DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int unsigned CH_W   = $clog2(NUM_CH);

   logic               w_press;
   logic [1:0]         r_mode_s1;
   mode_e              r_mode;
   state_e             r_state;
   state_e             w_state_nxt;
   logic [BURST_W-1:0] r_rem;
   logic [BURST_W-1:0] w_rem_nxt;
   logic               w_ce;
   logic               w_busy;
   logic [31:0]        r_cyc_cnt;

   key_debounce #(
      .DB_CYC (DB_CYC)
   ) u_key_debounce (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_key_n (key_step_n),
      .o_press (w_press)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode_s1 <= MODE_HALT;
         r_mode    <= MODE_HALT;
      end else begin
         r_mode_s1 <= mode_i;
         r_mode    <= mode_e'(r_mode_s1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   // Presses outside IDLE are simply not looked at, so they are dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_ce        = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_mode == MODE_RUN) begin
               w_state_nxt = S_RUN;
            end else if (w_press && (r_mode == MODE_STEP)) begin
               w_state_nxt = S_STEP;
            end else if (w_press && (r_mode == MODE_BURST) && (burst_len_i != '0)) begin
               w_state_nxt = S_BURST;
               w_rem_nxt   = burst_len_i;
            end
         end
         S_RUN: begin
            w_ce = 1'b1;
            if (r_mode != MODE_RUN) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_STEP: begin
            w_ce        = 1'b1;
            w_busy      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_BURST: begin
            w_ce      = 1'b1;
            w_busy    = 1'b1;
            w_rem_nxt = r_rem - 1'b1;
            if ((r_rem == BURST_W'(1)) || (r_mode != MODE_BURST)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cyc_cnt <= '0;
      end else if (w_ce) begin
         r_cyc_cnt <= r_cyc_cnt + 32'd1;
      end
   end

   // Enable and busy come straight from the state register so an
   // asynchronous reset removes them without waiting for a clock edge.
   assign cpu_ce_o  = w_ce;
   assign busy_o    = w_busy;
   assign cyc_cnt_o = r_cyc_cnt;

`ifdef DEBUG_STEP_HEX_EN
   logic [31:0]            w_sel_word;
   logic                   w_load;
   logic                   w_unused_sel;
   logic [CH_W-1:0]        r_ch_sel_q;
   logic                   r_ce_q;
   logic [NUM_HEX*4-1:0]   r_disp;
   logic                   r_disp_ld;
   logic [NUM_HEX*7-1:0]   r_hex;

   always_comb begin
      w_sel_word = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (ch_sel_i == CH_W'(k)) begin
            w_sel_word = dbg_i[k*32 +: 32];
         end
      end
   end

   assign w_unused_sel = ^w_sel_word;
   assign w_load = (r_state == S_RUN) || r_ce_q || (ch_sel_i != r_ch_sel_q);

   // The decode register only follows display loads, so the digits stay
   // blank after reset until something is actually loaded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ch_sel_q <= '0;
         r_ce_q     <= 1'b0;
         r_disp     <= '0;
         r_disp_ld  <= 1'b0;
         r_hex      <= {NUM_HEX{SEG_BLANK}};
      end else begin
         r_ch_sel_q <= ch_sel_i;
         r_ce_q     <= w_ce;
         r_disp_ld  <= w_load;
         if (w_load) begin
            r_disp <= w_sel_word[NUM_HEX*4-1:0];
         end
         if (r_disp_ld) begin
            for (int unsigned d = 0; d < NUM_HEX; d++) begin
               r_hex[d*7 +: 7] <= seg_decode(r_disp[d*4 +: 4]);
            end
         end
      end
   end

   assign hex_o = r_hex;
`else
   logic w_unused_disp;

   assign w_unused_disp = ^{ch_sel_i, dbg_i, CH_W[0]};
   assign hex_o = {NUM_HEX{SEG_BLANK}};
`endif

endmodule

// File: tb/tb_debug_step_ctrl.sv
module tb_debug_step_ctrl;

   localparam int unsigned NUM_CH  = 3;
   localparam int unsigned NUM_HEX = 6;
   localparam int unsigned BURST_W = 16;
   localparam int unsigned CW      = $clog2(NUM_CH);
   localparam int          DB      = 8;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic [1:0]              mode_i;
   logic                    key_step_n;
   logic [BURST_W-1:0]      burst_len_i;
   logic [CW-1:0]           ch_sel_i;
   logic [NUM_CH*32-1:0]    dbg_i;
   logic                    cpu_ce_o;
   logic                    busy_o;
   logic [31:0]             cyc_cnt_o;
   logic [NUM_HEX*7-1:0]    hex_o;

   debug_step_ctrl #(
      .CLK_HZ      (8000),
      .DEBOUNCE_MS (1),
      .NUM_CH      (NUM_CH),
      .NUM_HEX     (NUM_HEX),
      .BURST_W     (BURST_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mode_i      (mode_i),
      .key_step_n  (key_step_n),
      .burst_len_i (burst_len_i),
      .ch_sel_i    (ch_sel_i),
      .dbg_i       (dbg_i),
      .cpu_ce_o    (cpu_ce_o),
      .busy_o      (busy_o),
      .cyc_cnt_o   (cyc_cnt_o),
      .hex_o       (hex_o)
   );

   always #5 clk = ~clk;

   int tb_cyc = 0;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] cnt;
      logic        busy;
   } exp_t;

   exp_t        sb_q [$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          mon_en  = 1'b0;
   logic [31:0] m_cnt   = '0;
   logic [31:0] words [NUM_CH];
   logic [31:0] shown = '0;
   bit          shown_valid = 1'b0;

   // Expected enable pulse: absolute bench cycle, counter value seen during it, busy.
   task automatic expect_pulse(input int at, input logic busy);
      exp_t e;
      e.cyc  = at;
      e.cnt  = m_cnt;
      e.busy = busy;
      sb_q.push_back(e);
      m_cnt = m_cnt + 32'd1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (cpu_ce_o) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_ce cyc=%0d got ce=1 cnt=%h required no enable", tb_cyc, cyc_cnt_o);
            end else begin
               mon_e = sb_q.pop_front();
               if (mon_e.cyc != tb_cyc || mon_e.cnt !== cyc_cnt_o || mon_e.busy !== busy_o) begin
                  n_fail++;
                  $display("FAIL pulse got cyc=%0d cnt=%h busy=%b required cyc=%0d cnt=%h busy=%b",
                           tb_cyc, cyc_cnt_o, busy_o, mon_e.cyc, mon_e.cnt, mon_e.busy);
               end
            end
         end else begin
            n_tests++;
            if (busy_o !== 1'b0) begin
               n_fail++;
               $display("FAIL busy_without_ce cyc=%0d got busy=%b required 0", tb_cyc, busy_o);
            end
            if (sb_q.size() != 0 && sb_q[0].cyc <= tb_cyc) begin
               n_tests++;
               n_fail++;
               mon_e = sb_q.pop_front();
               $display("FAIL missed_ce cyc=%0d got ce=0 required ce=1 cnt=%h", tb_cyc, mon_e.cnt);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h required=%h", name, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_on(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   function automatic logic [NUM_HEX*7-1:0] exp_hex();
      logic [NUM_HEX*7-1:0] r;
      r = '1;
`ifdef DEBUG_STEP_HEX_EN
      if (shown_valid) begin
         for (int d = 0; d < NUM_HEX; d++) r[d*7 +: 7] = ~seg_on(shown[d*4 +: 4]);
      end
`endif
      return r;
   endfunction

   function automatic logic [31:0] sel_word();
      if (ch_sel_i < CW'(NUM_CH)) return words[ch_sel_i];
      return 32'h0;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_words();
      for (int k = 0; k < NUM_CH; k++) begin
         words[k] = $urandom;
         dbg_i[k*32 +: 32] = words[k];
      end
   endtask

   // Bounce the key nb times (low runs shorter than the debounce window),
   // then hold it low; c is the bench cycle of the final falling edge.
   task automatic press_key(input int nb, output int c);
      for (int i = 0; i < nb; i++) begin
         key_step_n = 1'b0;
         tick($urandom_range(DB - 1, 1));
         key_step_n = 1'b1;
         tick($urandom_range(4, 1));
      end
      key_step_n = 1'b0;
      c = tb_cyc;
   endtask

   task automatic release_key();
      key_step_n = 1'b1;
      tick(DB + 4);
   endtask

   task automatic wait_drain(input string name, input int limit);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < limit) begin
         tick(1);
         k++;
      end
      check({name, "_drain"}, 64'(sb_q.size()), 64'd0);
      sb_q.delete();
   endtask

   task automatic do_burst(input int len, input string name);
      int c;
      mode_i = 2'b11;
      burst_len_i = BURST_W'(len);
      tick(3);
      press_key($urandom_range(2, 0), c);
      for (int i = 0; i < len; i++) expect_pulse(c + DB + 3 + i, 1'b1);
      tick(DB + 6);
      release_key();
      wait_drain(name, len + 40);
      check({name, "_cnt"}, 64'(cyc_cnt_o), 64'(m_cnt));
      if (len > 0) begin
         shown = sel_word();
         shown_valid = 1'b1;
      end
      check({name, "_hex"}, 64'(hex_o), 64'(exp_hex()));
   endtask

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog got=timeout required=finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int m;
      int h;
      int r;
      mode_i      = 2'b00;
      key_step_n  = 1'b1;
      burst_len_i = '0;
      ch_sel_i    = '0;
      dbg_i       = '0;
      for (int k = 0; k < NUM_CH; k++) words[k] = '0;

      #23;
      check("rst_ce",   64'(cpu_ce_o),  64'd0);
      check("rst_busy", 64'(busy_o),    64'd0);
      check("rst_cnt",  64'(cyc_cnt_o), 64'd0);
      check("rst_hex",  64'(hex_o),     64'(exp_hex()));

      @(negedge clk);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      set_words();
      for (int i = 0; i < 10; i++) begin
         tick(10);
         check("halt_hex", 64'(hex_o), 64'(exp_hex()));
      end

      // single step with bounces
      mode_i = 2'b10;
      tick(3);
      press_key(3, c);
      expect_pulse(c + DB + 3, 1'b1);
      tick(DB + 6);
      release_key();
      wait_drain("step1", 40);
      check("step1_cnt", 64'(cyc_cnt_o), 64'd1);
      shown = sel_word();
      shown_valid = 1'b1;
      check("step1_hex", 64'(hex_o), 64'(exp_hex()));

      for (int it = 0; it < 4; it++) begin
         set_words();
         tick(3);
         check("hold_hex", 64'(hex_o), 64'(exp_hex()));
         press_key($urandom_range(3, 0), c);
         expect_pulse(c + DB + 3, 1'b1);
         tick(DB + 6);
         release_key();
         wait_drain("stepN", 40);
         check("stepN_cnt", 64'(cyc_cnt_o), 64'(m_cnt));
         shown = sel_word();
         check("stepN_hex", 64'(hex_o), 64'(exp_hex()));
      end

      do_burst(5, "burst5");
      check("burst5_total", 64'(cyc_cnt_o), 64'd10);
      for (int it = 0; it < 3; it++) begin
         set_words();
         do_burst($urandom_range(12, 1), "burstR");
      end

      // second press in the middle of a 40-cycle burst must be discarded
      mode_i = 2'b11;
      burst_len_i = 16'd40;
      tick(3);
      press_key(0, c);
      for (int i = 0; i < 40; i++) expect_pulse(c + DB + 3 + i, 1'b1);
      tick(DB + 4);
      key_step_n = 1'b1;
      tick(DB + 2);
      press_key(0, r);
      tick(DB + 6);
      release_key();
      wait_drain("burst_repress", 80);
      check("burst_repress_cnt", 64'(cyc_cnt_o), 64'(m_cnt));

      // zero-length burst is ignored
      burst_len_i = '0;
      tick(3);
      press_key(1, c);
      tick(DB + 6);
      release_key();
      wait_drain("burst0", 5);
      check("burst0_cnt", 64'(cyc_cnt_o), 64'(m_cnt));

      // channel select in HALT, including a channel beyond NUM_CH
      mode_i = 2'b00;
      words[2] = 32'h0012_3ABC;
      dbg_i[64 +: 32] = words[2];
      tick(4);
      ch_sel_i = 2'd2;
      tick(3);
      shown = 32'h0012_3ABC;
      shown_valid = 1'b1;
`ifdef DEBUG_STEP_HEX_EN
      check("hex_ch2", 64'(hex_o), 64'({~7'h06, ~7'h5B, ~7'h4F, ~7'h77, ~7'h7C, ~7'h39}));
`else
      check("hex_ch2", 64'(hex_o), 64'({NUM_HEX*7{1'b1}}));
`endif
      ch_sel_i = 2'd3;
      tick(3);
      shown = 32'h0;
      check("hex_ch3_zero", 64'(hex_o), 64'(exp_hex()));
      ch_sel_i = 2'd0;
      tick(3);
      shown = sel_word();
      check("hex_ch0", 64'(hex_o), 64'(exp_hex()));

      // burst of 100 aborted by switching to RUN, then continuous enable
      mode_i = 2'b11;
      burst_len_i = 16'd100;
      tick(3);
      press_key(0, c);
      m = c + DB + 3 + 20;
      h = m + 40;
      for (int t = c + DB + 3; t <= m + 2; t++) expect_pulse(t, 1'b1);
      for (int t = m + 4; t <= h + 2; t++) expect_pulse(t, 1'b0);
      tick(DB + 6);
      key_step_n = 1'b1;
      while (tb_cyc < m) tick(1);
      mode_i = 2'b01;
      tick(6);
      for (int i = 0; i < 5; i++) begin
         set_words();
         tick(4);
         shown = sel_word();
         check("run_hex", 64'(hex_o), 64'(exp_hex()));
      end
      while (tb_cyc < h) tick(1);
      mode_i = 2'b00;
      tick(6);
      wait_drain("abort_run", 10);
      check("abort_run_cnt", 64'(cyc_cnt_o), 64'(m_cnt));

      // counter wrap from a preloaded value
      @(negedge clk);
      force dut.r_cyc_cnt = 32'hFFFF_FFFE;
      tick(1);
      release dut.r_cyc_cnt;
      m_cnt = 32'hFFFF_FFFE;
      tick(1);
      check("preload", 64'(cyc_cnt_o), 64'h0000_0000_FFFF_FFFE);
      r = tb_cyc;
      for (int i = 0; i < 6; i++) expect_pulse(r + 3 + i, 1'b0);
      mode_i = 2'b01;
      tick(6);
      mode_i = 2'b00;
      tick(6);
      wait_drain("wrap", 10);
      check("wrap_cnt", 64'(cyc_cnt_o), 64'd4);

      // asynchronous reset in the middle of a burst
      mode_i = 2'b11;
      burst_len_i = 16'd100;
      tick(3);
      press_key(0, c);
      for (int i = 0; i < 100; i++) expect_pulse(c + DB + 3 + i, 1'b1);
      tick(DB + 6);
      key_step_n = 1'b1;
      tick(12);
      check("pre_reset_ce", 64'(cpu_ce_o), 64'd1);
      mon_en = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_ce",   64'(cpu_ce_o),  64'd0);
      check("async_rst_busy", 64'(busy_o),    64'd0);
      check("async_rst_cnt",  64'(cyc_cnt_o), 64'd0);
      check("async_rst_hex",  64'(hex_o),     64'({NUM_HEX*7{1'b1}}));
      sb_q.delete();
      m_cnt = '0;
      shown_valid = 1'b0;
      tick(3);
      reset_n = 1'b1;
      mon_en = 1'b1;
      tick(DB + 20);
      check("post_reset_cnt", 64'(cyc_cnt_o), 64'd0);
      check("post_reset_hex", 64'(hex_o), 64'(exp_hex()));
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
